// File: rtl/sort_sequencer.sv
// Control sequencer for an in-place bubble sort over NUM_ENTRIES datapath registers:
// loads entries one strobe at a time, then walks compare/swap passes until sorted.
// Optional macro SORT_SEQUENCER_EARLY_EXIT_EN: stop after the first pass without a swap.
module sort_sequencer #(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load_strobe,
    input  logic             gt,
    output logic             load_en,
    output logic [IDX_W-1:0] load_idx,
    output logic [IDX_W-1:0] cmp_idx,
    output logic             swap_en,
    output logic             busy,
    output logic             done,
    output logic [5:0]       swap_count
);

    if (IDX_W != $clog2(NUM_ENTRIES)) begin : g_bad_idx_w
        $error("sort_sequencer: IDX_W must equal clog2(NUM_ENTRIES)");
    end
    if (NUM_ENTRIES < 2 || NUM_ENTRIES > 8) begin : g_bad_entries
        $error("sort_sequencer: NUM_ENTRIES must be in 2..8");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPARE,
        SWAP,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(NUM_ENTRIES - 2);
    localparam logic [5:0]       SWAP_MAX  = 6'd63;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] load_idx_q, load_idx_d;
    logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
    logic [IDX_W-1:0] pass_q, pass_d;
    logic [5:0]       swap_count_q, swap_count_d;
    logic [IDX_W-1:0] last_cmp;
    logic             advance;
    logic             pass_clean;

`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
    logic swapped_q, swapped_d;
`endif

    // Each pass shortens by one: the largest remaining entry has bubbled to the top.
    assign last_cmp = LAST_PASS - pass_q;

    always_comb begin
        // NOTE: every combinational output and next-state value gets a default here,
        // so no path through the case below can leave one unassigned and infer a latch.
        state_d      = state_q;
        load_idx_d   = load_idx_q;
        cmp_idx_d    = cmp_idx_q;
        pass_d       = pass_q;
        swap_count_d = swap_count_q;
        load_en      = 1'b0;
        swap_en      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        advance      = 1'b0;
        pass_clean   = 1'b0;
`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
        swapped_d    = swapped_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    load_idx_d   = IDX_ZERO;
                    cmp_idx_d    = IDX_ZERO;
                    pass_d       = IDX_ZERO;
                    swap_count_d = '0;
                end
            end

            LOAD: begin
                busy = 1'b1;
                if (load_strobe) begin
                    // Reset wins over a same-cycle strobe, so no datapath write slips through.
                    load_en = !rst;
                    if (load_idx_q == LAST_IDX) begin
                        state_d    = COMPARE;
                        load_idx_d = IDX_ZERO;
                        cmp_idx_d  = IDX_ZERO;
                        pass_d     = IDX_ZERO;
`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
                        swapped_d  = 1'b0;
`endif
                    end else begin
                        load_idx_d = load_idx_q + IDX_ONE;
                    end
                end
            end

            COMPARE: begin
                busy = 1'b1;
                if (gt) begin
                    state_d = SWAP;
                end else begin
                    advance = 1'b1;
                end
            end

            SWAP: begin
                busy    = 1'b1;
                swap_en = 1'b1;
                advance = 1'b1;
                if (swap_count_q != SWAP_MAX) begin
                    swap_count_d = swap_count_q + 6'd1;
                end
`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
                swapped_d = 1'b1;
`endif
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
        // swapped_d already includes a swap taken in this very cycle.
        pass_clean = !swapped_d;
`endif

        if (advance) begin
            if (cmp_idx_q < last_cmp) begin
                state_d   = COMPARE;
                cmp_idx_d = cmp_idx_q + IDX_ONE;
            end else if (pass_q == LAST_PASS || pass_clean) begin
                state_d = DONE;
            end else begin
                state_d   = COMPARE;
                pass_d    = pass_q + IDX_ONE;
                cmp_idx_d = IDX_ZERO;
`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
                swapped_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the pre-edge values,
        // independent of statement order inside this block.
        if (rst) begin
            state_q      <= IDLE;
            load_idx_q   <= IDX_ZERO;
            cmp_idx_q    <= IDX_ZERO;
            pass_q       <= IDX_ZERO;
            swap_count_q <= '0;
`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
            swapped_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            cmp_idx_q    <= cmp_idx_d;
            pass_q       <= pass_d;
            swap_count_q <= swap_count_d;
`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
            swapped_q    <= swapped_d;
`endif
        end
    end

    assign load_idx   = load_idx_q;
    assign cmp_idx    = cmp_idx_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: a small 4-entry datapath model answers gt and applies
// load/swap strobes; directed vectors check counts, timing and final order.
module tb_sort_sequencer;

    localparam int N  = 4;
    localparam int IW = 2;

`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          load_strobe;
    logic          gt;
    logic          load_en;
    logic [IW-1:0] load_idx;
    logic [IW-1:0] cmp_idx;
    logic          swap_en;
    logic          busy;
    logic          done;
    logic [5:0]    swap_count;

    logic [7:0]    din;
    logic [7:0]    ent [N];

    int n_checks = 0;
    int n_fail   = 0;

    sort_sequencer #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_strobe(load_strobe),
        .gt         (gt),
        .load_en    (load_en),
        .load_idx   (load_idx),
        .cmp_idx    (cmp_idx),
        .swap_en    (swap_en),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    // Datapath model: register file written by load_en, pair exchanged by swap_en.
    always @(posedge clk) begin
        if (load_en) ent[load_idx] <= din;
        if (swap_en) begin
            ent[cmp_idx]          <= ent[cmp_idx + IW'(1)];
            ent[cmp_idx + IW'(1)] <= ent[cmp_idx];
        end
    end

    always_comb gt = (cmp_idx < IW'(N - 1)) ? (ent[cmp_idx] > ent[cmp_idx + IW'(1)]) : 1'b0;

    typedef struct {
        logic [31:0] data;       // entry i in bits [8*i +: 8]
        int          compares;
        int          swaps;
        int          latency;    // cycles from first sort cycle to done, inclusive
        int          last_swap;  // compare number at which the last swap happened
        logic [31:0] sorted;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] model_word();
        return {ent[3], ent[2], ent[1], ent[0]};
    endfunction

    // Starts at a negedge with idle inputs; returns at a negedge with the DUT idle.
    task automatic run_vec(input int vi, input bit disturb, input string tag);
        int compares  = 0;
        int swaps     = 0;
        int latency   = -1;
        int last_swap = 0;
        int overlap   = 0;
        int bad_load  = 0;
        logic [5:0] sc_at_done = '0;
        logic [31:0] data = vecs[vi].data;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_load"}, busy, 1);
        for (int i = 0; i < N; i++) begin
            load_strobe = 1'b1;
            din = data[8*i +: 8];
            #1;
            if (load_en !== 1'b1 || load_idx !== IW'(i)) bad_load++;
            @(negedge clk);
        end
        load_strobe = 1'b0;
        din = '0;

        for (int k = 1; k <= 40; k++) begin
            if (load_en && swap_en) overlap++;
            if (load_en) bad_load++;
            if (done) begin
                latency    = k;
                sc_at_done = swap_count;
                break;
            end
            if (swap_en) begin
                swaps++;
                last_swap = compares;
            end else if (busy) begin
                compares++;
            end
            if (disturb && k == 1) start = 1'b1;
            if (disturb && k == 2) begin
                start = 1'b0;
                load_strobe = 1'b1;
                #1;
                if (load_en) bad_load++;
            end
            if (disturb && k == 3) load_strobe = 1'b0;
            @(negedge clk);
        end

        // A start during DONE must not relaunch the sequencer.
        if (disturb) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_clear"}, {busy, done}, 2'b00);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);

        check({tag, "_compares"},   compares,   vecs[vi].compares);
        check({tag, "_swaps"},      swaps,      vecs[vi].swaps);
        check({tag, "_latency"},    latency,    vecs[vi].latency);
        check({tag, "_last_swap"},  last_swap,  vecs[vi].last_swap);
        check({tag, "_swap_count"}, sc_at_done, vecs[vi].swaps);
        check({tag, "_count_hold"}, swap_count, vecs[vi].swaps);
        check({tag, "_sorted"},     model_word(), vecs[vi].sorted);
        check({tag, "_overlap"},    overlap,    0);
        check({tag, "_bad_load"},   bad_load,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           data          cmp                 swp lat                       last sorted
        vecs[0] = '{32'h01020304, 6,                  6, 13,                      6, 32'h04030201};
        vecs[1] = '{32'h04030201, EARLY ? 3 : 6,      0, EARLY ? 4 : 7,           0, 32'h04030201};
        vecs[2] = '{32'h03040102, EARLY ? 5 : 6,      2, EARLY ? 8 : 9,           3, 32'h04030201};
        vecs[3] = '{32'h07010905, 6,                  3, 10,                      4, 32'h09070501};
        vecs[4] = '{32'h07070707, EARLY ? 3 : 6,      0, EARLY ? 4 : 7,           0, 32'h07070707};
        vecs[5] = '{32'h00010302, 6,                  5, 12,                      6, 32'h03020100};

        rst = 1'b1;
        start = 1'b0;
        load_strobe = 1'b1;
        din = '0;
        for (int i = 0; i < N; i++) ent[i] = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {load_en, load_idx, cmp_idx, swap_en, busy, done, swap_count}, '0);
        rst = 1'b0;
        load_strobe = 1'b0;
        @(negedge clk);
        check("reset_idle", {busy, done, load_en}, 3'b000);

        for (int vi = 0; vi < 6; vi++) run_vec(vi, 1'b0, $sformatf("v%0d", vi));

        // Reset during the first SWAP of pass 1 (sort cycle 8 for 4,3,2,1).
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            load_strobe = 1'b1;
            din = vecs[0].data[8*i +: 8];
            @(negedge clk);
        end
        load_strobe = 1'b0;
        repeat (7) @(negedge clk);
        check("midswap_state", {swap_en, busy, cmp_idx, swap_count}, {1'b1, 1'b1, 2'd0, 6'd3});
        rst = 1'b1;
        @(negedge clk);
        check("midswap_reset", {load_en, load_idx, cmp_idx, swap_en, busy, done, swap_count}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("midswap_idle", {busy, done}, 2'b00);
        run_vec(2, 1'b0, "after_swap_rst");

        // Reset mid-LOAD together with a strobe, then reset together with start.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_strobe = 1'b1;
            din = 8'h55;
            @(negedge clk);
        end
        check("midload_idx", load_idx, 2);
        rst = 1'b1;
        @(negedge clk);
        load_strobe = 1'b0;
        check("midload_reset", {load_en, load_idx, cmp_idx, swap_en, busy, done, swap_count}, '0);
        start = 1'b1;
        @(negedge clk);
        check("rst_over_start", busy, 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_over_start_idle", busy, 0);
        run_vec(3, 1'b0, "after_load_rst");

        // start pulsed in COMPARE, load_strobe in SWAP, start in DONE: all ignored.
        run_vec(0, 1'b1, "disturb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
